ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter for the keyboard design: sends command bytes to the keyboard, e.g. 0xED "set LEDs" followed by the LED mask.
- Drives the shared open-drain PS/2 clock and data lines through active-high output-enable pins; a 1 pulls the line low.
- Implements the inhibit/request-to-send sequence, odd parity, stop bit, device-ACK check and timeout.
- Sits beside the existing PS/2 receiver on the same pins; the receiver ignores traffic while busy=1.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum clk cycles allowed between device falling edges, or from request to the first edge (15 ms at 50 MHz).
- FILTER_LEN, 8: number of consecutive equal samples required before a synchronized line level is accepted.

Ports:
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  asynchronous active-low reset
- tx_data  input  8  byte to send
- tx_valid  input  1  send request; accepted when tx_valid=1 and tx_ready=1 in the same cycle
- tx_ready  output  1  high only in IDLE
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when a frame completes, with or without ACK
- ack_ok  output  1  valid while done=1: 1 = device ACK received
- err_timeout  output  1  one-cycle pulse when a transfer is aborted by timeout
- ps2_clk_i  input  1  raw PS/2 clock line
- ps2_data_i  input  1  raw PS/2 data line
- ps2_clk_oe  output  1  1 = pull PS/2 clock low
- ps2_data_oe  output  1  1 = pull PS/2 data low

Behaviour:
- Reset (async assert, sync release) values:
  - All outputs 0 except tx_ready=1; both lines released.
  - State = IDLE; counters and shift register cleared.
  - Reset asserted mid-frame releases both lines immediately. No done or err_timeout pulse is produced.
- Input conditioning: each raw line passes a 2-FF synchronizer, then a FILTER_LEN glitch filter. A filtered-clock fall (1->0) gives a one-cycle fall strobe. Strobe latency is 2+FILTER_LEN cycles after the raw edge.
- Handshake acceptance: on acceptance, latch tx_data and compute parity = ~^tx_data (odd parity). Build the 10-bit frame {stop=1, parity, data[7:0]}, shifted out LSB first. tx_valid while busy is ignored.
- IDLE: tx_ready=1, both oe=0. On acceptance -> INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0, count INHIBIT_CYCLES. On expiry, assert data_oe=1 (start bit 0) together with clk_oe=1 for 1 cycle, then -> REQ.
- REQ: clk_oe=0, data_oe=1; wait for a fall strobe.
- On each fall strobe in REQ or BITS: data_oe = ~current frame bit, then shift.
  - Falls 1-8 present data bits 0-7.
  - Fall 9 presents parity.
  - Fall 10 presents the stop bit: data_oe=0, line released.
  - After fall 10 -> ACK.
- ACK: wait for fall 11 and sample filtered data at that strobe. Data=0 means ACK (ack_ok=1); otherwise ack_ok=0. Then -> WAIT_IDLE.
- WAIT_IDLE: wait until filtered clk=1 and data=1, then pulse done with ack_ok, -> IDLE.
- Bit counter: 4 bits, counts falls 1-11, clears on entering INHIBIT.
- Timeout: counter reloads on entering REQ and on every fall strobe, and runs in REQ, BITS, ACK and WAIT_IDLE. On reaching TIMEOUT_CYCLES: release both lines, pulse err_timeout for 1 cycle, -> IDLE. No done pulse is produced.
- A fall strobe and a timeout in the same cycle: the strobe wins.
- ack_ok holds its value until the next acceptance.
- Outputs are registered; no combinational path from the ps2 inputs to any output.

Decomposition:
- Package ps2_pkg holds:
  - state enum {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE};
  - FRAME_BITS=10;
  - default INHIBIT/TIMEOUT cycle constants.
- The receiver shares this package.
- One sub-module, ps2_line_sync (synchronizer + FILTER_LEN filter + fall strobe), instantiated once per line. The receiver reuses it.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs.
  - Required: clk held low ≥5000 cycles.
  - Data sampled on device rising edges = 0,1,0,1,1,0,1,1,1,1,1 (start, LSB-first data, parity 1, stop).
  - done pulse with ack_ok=1; tx_ready returns to 1.
- Send 0x01.
  - Required: parity bit 0, stop 1, ACK -> done and ack_ok=1.
  - tx_valid pulsed mid-frame is ignored; tx_ready=0 throughout.
- Device never clocks.
  - Required: err_timeout pulses exactly TIMEOUT_CYCLES after entering REQ.
  - Both oe=0; no done pulse.
- Device clocks the 11th edge without pulling data low.
  - Required: done=1 with ack_ok=0.
- rst_n asserted after the 4th data bit.
  - Required: ps2_clk_oe=0 and ps2_data_oe=0 asynchronously; tx_ready=1 after release.
  - A fresh 0xF4 then transmits correctly.
- 3-cycle glitch on ps2_clk_i during BITS (FILTER_LEN=8).
  - Required: no extra bit shifted; frame still matches the 0xED sequence.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the receiver.
package ps2_pkg;

    localparam int unsigned FRAME_BITS         = 10;
    localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;
    localparam int unsigned DEF_FILTER_LEN     = 8;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        BITS,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    // Host frame as shifted out LSB first: data, then odd parity, then stop.
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

    function automatic ps2_frame_t build_frame(input logic [7:0] data);
        ps2_frame_t f;
        f.stop   = 1'b1;
        f.parity = ~^data;
        f.data   = data;
        return f;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioner: 2-FF synchronizer, consecutive-sample glitch filter
// and a registered one-cycle strobe on each accepted 1->0 transition.
module ps2_line_sync #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // Idle bus level is high, so everything resets to the released state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            cnt   <= '0;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            meta <= line;
            sync <= meta;
            fall <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                cnt   <= '0;
                level <= sync;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, device ACK check and inter-edge timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned IW = (INHIBIT_CYCLES > 0) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic                  clk_level;
    logic                  clk_fall;
    logic                  data_level;
    logic                  data_fall_unused;
    ps2_state_t            state;
    logic [FRAME_BITS-1:0] shreg;
    logic [3:0]            bit_cnt;
    logic [IW-1:0]         icnt;
    logic [TW-1:0]         tcnt;
    logic                  ack_seen;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (ps2_clk_i),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_data_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (ps2_data_i),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            icnt        <= '0;
            tcnt        <= '0;
            ack_seen    <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            err_timeout <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            done        <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg      <= build_frame(tx_data);
                        bit_cnt    <= '0;
                        icnt       <= '0;
                        ack_seen   <= 1'b0;
                        ack_ok     <= 1'b0;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end
                end

                // Last inhibit cycle overlaps the start bit with the clock still held.
                INHIBIT: begin
                    icnt <= icnt + 1'b1;
                    if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
                        ps2_data_oe <= 1'b1;
                    end
                    if (icnt == IW'(INHIBIT_CYCLES)) begin
                        ps2_clk_oe <= 1'b0;
                        tcnt       <= '0;
                        state      <= REQ;
                    end
                end

                REQ, BITS, ACK, WAIT_IDLE: begin
                    if (clk_fall) begin
                        tcnt <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end

                    // A device edge always takes priority over an expiring timeout.
                    if (clk_fall && state != WAIT_IDLE) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (state == ACK) begin
                            ack_seen <= ~data_level;
                            state    <= WAIT_IDLE;
                        end else begin
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= shreg >> 1;
                            state       <= (bit_cnt == 4'd9) ? ACK : BITS;
                        end
                    end else if (state == WAIT_IDLE && clk_level && data_level) begin
                        done     <= 1'b1;
                        ack_ok   <= ack_seen;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (!clk_fall && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        err_timeout <= 1'b1;
                        tx_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready    <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a device model; the bits the device
// reads are scored against a frame model built from plain arithmetic on the byte.
module tb_ps2_host_tx;

    localparam int INHIBIT  = 5000;
    localparam int TIMEOUT  = 3000;
    localparam int HALF     = 100;   // device clock half period, scaled down for run time
    localparam int END_NONE = 0;
    localparam int END_DONE = 1;
    localparam int END_TO   = 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err_timeout;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    logic dev_clk_low;
    logic dev_data_low;
    logic glitch;

    int   vectors;
    int   miscompares;
    int   exp_end;
    logic exp_ack;
    logic got_q[$];
    logic exp_q[$];

    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low | glitch);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FILTER_LEN     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .ack_ok      (ack_ok),
        .err_timeout (err_timeout),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit k is what the device must read at its k-th sample: start, data LSB first, parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] r;
        int ones;
        ones = 0;
        r[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r[i + 1] = b[i];
            ones += int'(b[i]);
        end
        r[9]  = (ones % 2 == 0);
        r[10] = 1'b1;
        return r;
    endfunction

    // Scoreboard and per-cycle output rules.
    always @(negedge clk) begin
        check("busy_vs_ready", 32'(busy), 32'(!tx_ready));
        if (tx_ready) check("idle_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        if (done || err_timeout) begin
            check("done_pulse", 32'(done), 32'(exp_end == END_DONE));
            check("timeout_pulse", 32'(err_timeout), 32'(exp_end == END_TO));
            if (done) check("ack_ok", 32'(ack_ok), 32'(exp_ack));
        end
        while (got_q.size() > 0) begin
            if (exp_q.size() == 0) begin
                check("extra_frame_bit", 32'(got_q.size()), 32'd0);
                got_q.delete();
            end else begin
                check("frame_bit", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        logic [10:0] f;
        check("ready_before_send", 32'(tx_ready), 32'd1);
        f = frame_bits(b);
        for (int i = 0; i < 11; i++) exp_q.push_back(f[i]);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Returns on the first cycle the clock line is released.
    task automatic check_inhibit();
        int hi;
        int both;
        hi   = 0;
        both = 0;
        while (ps2_clk_oe && hi < 4 * INHIBIT) begin
            hi++;
            if (ps2_data_oe) both++;
            @(negedge clk);
        end
        check("inhibit_len", 32'(hi), 32'(INHIBIT + 1));
        check("start_overlap", 32'(both), 32'd1);
        check("req_data_oe", 32'(ps2_data_oe), 32'd1);
    endtask

    task automatic dev_frame(input int n_clk, input bit ack, input bit glitch_en);
        got_q.push_back(ps2_data_i);
        repeat (50) @(negedge clk);
        for (int k = 1; k <= n_clk; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) got_q.push_back(ps2_data_i);
            if (k == 11) dev_data_low = 1'b0;
            if (k < 11) begin
                for (int c = 0; c < HALF; c++) begin
                    if (glitch_en && k == 4) glitch = (c >= 30 && c < 33);
                    if (ack && k == 10 && c == HALF / 2) dev_data_low = 1'b1;
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!(done || err_timeout) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_end_seen"}, 32'(done || err_timeout), 32'd1);
        if (done || err_timeout) begin
            @(negedge clk);
            check({name, "_pulse_width"}, 32'({done, err_timeout}), 32'd0);
        end
        exp_end = END_NONE;
    endtask

    initial begin
        int c;
        vectors      = 0;
        miscompares  = 0;
        exp_end      = END_NONE;
        exp_ack      = 1'b0;
        rst_n        = 1'b0;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        glitch       = 1'b0;

        repeat (5) @(negedge clk);
        check("reset_outputs",
              32'({tx_ready, busy, done, ack_ok, err_timeout, ps2_clk_oe, ps2_data_oe}), 32'h40);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        check("model_ed", 32'(frame_bits(8'hED)), 32'(11'b11111011010));
        check("model_01", 32'(frame_bits(8'h01)), 32'(11'b10000000010));
        check("model_f4", 32'(frame_bits(8'hF4)), 32'(11'b10111101000));

        // 0xED, device ACKs
        exp_end = END_DONE; exp_ack = 1'b1;
        send(8'hED);
        check_inhibit();
        dev_frame(11, 1'b1, 1'b0);
        wait_end("ed");
        check("ed_bits_left", 32'(exp_q.size()), 32'd0);
        repeat (10) @(negedge clk);
        check("ack_ok_hold", 32'(ack_ok), 32'd1);

        // 0x01 with a request pulsed mid-frame
        exp_end = END_DONE; exp_ack = 1'b1;
        send(8'h01);
        check_inhibit();
        fork
            dev_frame(11, 1'b1, 1'b0);
            begin
                repeat (600) @(negedge clk);
                check("ready_mid_frame", 32'(tx_ready), 32'd0);
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        wait_end("x01");
        check("x01_bits_left", 32'(exp_q.size()), 32'd0);
        repeat (200) @(negedge clk);
        check("no_restart", 32'({ps2_clk_oe, tx_ready}), 32'd1);

        // device never clocks
        exp_end = END_TO;
        send(8'h55);
        check_inhibit();
        c = 0;
        while (!err_timeout && c < 3 * TIMEOUT) begin
            @(negedge clk);
            c++;
        end
        check("timeout_cycles", 32'(c), 32'(TIMEOUT));
        check("timeout_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        check("timeout_width", 32'(err_timeout), 32'd0);
        exp_end = END_NONE;
        repeat (50) @(negedge clk);

        // device clocks the 11th edge without ACK
        exp_end = END_DONE; exp_ack = 1'b0;
        send(8'hA5);
        check_inhibit();
        dev_frame(11, 1'b0, 1'b0);
        wait_end("noack");
        check("noack_bits_left", 32'(exp_q.size()), 32'd0);

        // reset while bit 4 (a 0) is being driven
        exp_end = END_NONE;
        send(8'hED);
        check_inhibit();
        dev_frame(4, 1'b0, 1'b0);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        check("pre_reset_data_oe", 32'(ps2_data_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        dev_clk_low = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("ready_after_reset", 32'(tx_ready), 32'd1);

        exp_end = END_DONE; exp_ack = 1'b1;
        send(8'hF4);
        check_inhibit();
        dev_frame(11, 1'b1, 1'b0);
        wait_end("f4");
        check("f4_bits_left", 32'(exp_q.size()), 32'd0);

        // 3-cycle clock glitch during the data bits
        exp_end = END_DONE; exp_ack = 1'b1;
        send(8'hED);
        check_inhibit();
        dev_frame(11, 1'b1, 1'b1);
        wait_end("glitch");
        check("glitch_bits_left", 32'(exp_q.size()), 32'd0);

        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
